// File: rtl/psk_tx_pkg.sv
// psk_tx_pkg: shared state encoding and bit-to-symbol mapping for the PSK transmitter.
package psk_tx_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA, ST_TAIL} state_t;
  localparam logic BIT_POS = 1'b0;
  function automatic logic signed [15:0] map_bit(input logic b, input logic signed [15:0] amp);
    return (b == BIT_POS) ? amp : -amp;
  endfunction
endpackage

// File: rtl/psk_symbol_interp.sv
// psk_symbol_interp: linear ramp from prev to cur, evaluated at the current phase.
module psk_symbol_interp #(
  parameter int LOG2_SPS = 5
) (
  input  logic signed [15:0]    i_prev,
  input  logic signed [15:0]    i_cur,
  input  logic [LOG2_SPS-1:0]   i_phase,
  output logic signed [15:0]    o_sample
);
  localparam int W = LOG2_SPS + 19;
  logic signed [17:0] w_diff;
  assign w_diff = {{2{i_cur[15]}}, i_cur} - {{2{i_prev[15]}}, i_prev};
  // product is kept wide enough for any phase; |result| never exceeds AMP
  assign o_sample = i_prev + 16'((W'(w_diff) * W'($signed({1'b0, i_phase}))) >>> LOG2_SPS);
endmodule

// File: rtl/psk_baseband_tx.sv
// psk_baseband_tx: framed BPSK/QPSK symbol mapper emitting linearly interpolated I/Q samples.
module psk_baseband_tx
  import psk_tx_pkg::*;
#(
  parameter int SPS           = 32,
  parameter int LOG2_SPS      = 5,
  parameter int PREAMBLE_SYMS = 32,
  parameter int AMP           = 8192
) (
  input  logic        clk_32M768,
  input  logic        rst_32M768,
  input  logic        is_bpsk,
  input  logic        start,
  input  logic [1:0]  bit_tdata,
  input  logic        bit_tvalid,
  output logic        bit_tready,
  input  logic        bit_tlast,
  output logic [15:0] I_tdata,
  output logic        I_tvalid,
  output logic [15:0] Q_tdata,
  output logic        Q_tvalid,
  output logic        sym_strobe,
  output logic        busy,
  output logic        underrun
);
  localparam int CW = $clog2(PREAMBLE_SYMS + 1);
  localparam logic signed [15:0] AMP_S = 16'(AMP);
  state_t r_state, w_state;
  logic [LOG2_SPS-1:0] r_phase, w_phase;
  logic signed [15:0] r_prev_i, r_cur_i, r_prev_q, r_cur_q;
  logic signed [15:0] w_prev_i, w_cur_i, w_prev_q, w_cur_q;
  logic signed [15:0] w_di, w_dq, w_si, w_sq, r_i, r_q;
  logic [CW-1:0] r_cnt, w_cnt;
  logic r_bpsk, w_bpsk, r_last, w_last, w_under, w_bnd, w_load;
  logic r_valid, r_strobe, r_under;
  assign w_bnd  = (r_state != ST_IDLE) && (r_phase == LOG2_SPS'(SPS - 1));
  // a data symbol is fetched at the boundary ending the last preamble symbol or any non-final data symbol
  assign w_load = w_bnd && ((r_state == ST_PREAMBLE && r_cnt == CW'(PREAMBLE_SYMS)) ||
                            (r_state == ST_DATA && !r_last));
  assign w_di   = map_bit(r_bpsk ? bit_tdata[0] : bit_tdata[1], AMP_S);
  assign w_dq   = r_bpsk ? '0 : map_bit(bit_tdata[0], AMP_S);
  always_comb begin
    w_state  = r_state;
    w_phase  = r_phase;
    w_prev_i = r_prev_i;
    w_cur_i  = r_cur_i;
    w_prev_q = r_prev_q;
    w_cur_q  = r_cur_q;
    w_bpsk   = r_bpsk;
    w_cnt    = r_cnt;
    w_last   = r_last;
    w_under  = 1'b0;
    if (r_state == ST_IDLE) begin
      if (start) begin
        w_state  = ST_PREAMBLE;
        w_bpsk   = is_bpsk;
        w_prev_i = '0;
        w_prev_q = '0;
        w_cur_i  = AMP_S;
        w_cur_q  = is_bpsk ? '0 : AMP_S;
        w_cnt    = CW'(1);
        w_last   = 1'b0;
      end
    end else begin
      w_phase = r_phase + 1'b1;
      if (w_bnd) begin
        w_prev_i = r_cur_i;
        w_prev_q = r_cur_q;
        if (w_load) begin
          w_state = ST_DATA;
          w_cur_i = bit_tvalid ? w_di : '0;
          w_cur_q = bit_tvalid ? w_dq : '0;
          w_last  = bit_tvalid & bit_tlast;
          w_under = ~bit_tvalid;
        end else if (r_state == ST_PREAMBLE) begin
          w_cur_i = -r_cur_i;
          w_cur_q = -r_cur_q;
          w_cnt   = r_cnt + 1'b1;
        end else if (r_state == ST_DATA) begin
          w_state = ST_TAIL;
          w_cur_i = '0;
          w_cur_q = '0;
        end else begin
          w_state = ST_IDLE;
        end
      end
    end
  end
  psk_symbol_interp #(.LOG2_SPS(LOG2_SPS)) u_interp_i (
    .i_prev(r_prev_i), .i_cur(r_cur_i), .i_phase(r_phase), .o_sample(w_si)
  );
  psk_symbol_interp #(.LOG2_SPS(LOG2_SPS)) u_interp_q (
    .i_prev(r_prev_q), .i_cur(r_cur_q), .i_phase(r_phase), .o_sample(w_sq)
  );
  always_ff @(posedge clk_32M768) begin
    if (rst_32M768) begin
      r_state  <= ST_IDLE;
      r_phase  <= '0;
      r_prev_i <= '0;
      r_cur_i  <= '0;
      r_prev_q <= '0;
      r_cur_q  <= '0;
      r_bpsk   <= 1'b0;
      r_cnt    <= '0;
      r_last   <= 1'b0;
      r_i      <= '0;
      r_q      <= '0;
      r_valid  <= 1'b0;
      r_strobe <= 1'b0;
      r_under  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_phase  <= w_phase;
      r_prev_i <= w_prev_i;
      r_cur_i  <= w_cur_i;
      r_prev_q <= w_prev_q;
      r_cur_q  <= w_cur_q;
      r_bpsk   <= w_bpsk;
      r_cnt    <= w_cnt;
      r_last   <= w_last;
      r_i      <= w_si;
      r_q      <= w_sq;
      r_valid  <= r_state != ST_IDLE;
      r_strobe <= w_bnd;
      r_under  <= w_under;
    end
  end
  assign bit_tready = w_load;
  assign busy       = r_state != ST_IDLE;
  assign I_tdata    = r_i;
  assign Q_tdata    = r_q;
  assign I_tvalid   = r_valid;
  assign Q_tvalid   = r_valid;
  assign sym_strobe = r_strobe;
  assign underrun   = r_under;
endmodule

// File: tb/tb_psk_baseband_tx.sv
// tb_psk_baseband_tx: random framed stimulus checked each cycle against a symbol-list waveform model.
module tb_psk_baseband_tx;
  localparam int SPS = 32, LOG2 = 5, P = 2, AMP = 8192;
  logic clk = 0, rst = 1, is_bpsk = 0, start = 0, bit_tvalid = 0, bit_tlast = 0;
  logic [1:0] bit_tdata = 0;
  logic bit_tready, I_tvalid, Q_tvalid, sym_strobe, busy, underrun;
  logic [15:0] I_tdata, Q_tdata;
  int tests = 0, fails = 0;
  int si[$], sq[$];
  int m_busy = 0, m_t = 0, m_bpsk = 0, m_last = 0, m_tail = -1;
  int log_i[4096], log_q[4096];
  int vcnt = 0, last_v = 0, last_rdy = 0;
  int busy_cnt = 0, strobe_cnt = 0, under_cnt = 0, hs_cnt = 0, rdy_cnt = 0, valid_cnt = 0;
  logic [1:0] fdat[3] = '{2'b00, 2'b10, 2'b11};

  psk_baseband_tx #(.SPS(SPS), .LOG2_SPS(LOG2), .PREAMBLE_SYMS(P), .AMP(AMP)) dut (
    .clk_32M768(clk), .rst_32M768(rst), .is_bpsk(is_bpsk), .start(start),
    .bit_tdata(bit_tdata), .bit_tvalid(bit_tvalid), .bit_tready(bit_tready), .bit_tlast(bit_tlast),
    .I_tdata(I_tdata), .I_tvalid(I_tvalid), .Q_tdata(Q_tdata), .Q_tvalid(Q_tvalid),
    .sym_strobe(sym_strobe), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic int mapb(logic b);
    return b ? -AMP : AMP;
  endfunction

  function automatic int lerp(int p, int c, int ph);
    return p + (((c - p) * ph) >>> LOG2);
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int k, ph, e_i, e_q, e_v, e_s, e_u, e_r, p_i, p_q, v;
    #1;
    k = m_t / SPS;
    ph = m_t % SPS;
    e_i = 0; e_q = 0; e_v = 0; e_s = 0; e_u = 0;
    if (m_busy != 0) begin
      p_i = (k > 0) ? si[k-1] : 0;
      p_q = (k > 0) ? sq[k-1] : 0;
      e_i = lerp(p_i, si[k], ph);
      e_q = lerp(p_q, sq[k], ph);
      e_v = 1;
      e_s = (ph == SPS - 1) ? 1 : 0;
    end
    if (rst) begin
      e_i = 0; e_q = 0; e_v = 0; e_s = 0;
      m_busy = 0; m_t = 0; m_last = 0; m_tail = -1;
      si.delete(); sq.delete();
    end else if (m_busy == 0) begin
      if (start) begin
        si.delete(); sq.delete();
        m_bpsk = int'(is_bpsk);
        si.push_back(AMP);
        sq.push_back(is_bpsk ? 0 : AMP);
        m_busy = 1; m_t = 0; m_last = 0; m_tail = -1;
      end
    end else if (ph == SPS - 1) begin
      if (k + 1 < P) begin
        v = ((k + 1) % 2 != 0) ? -AMP : AMP;
        si.push_back(v);
        sq.push_back(m_bpsk != 0 ? 0 : v);
      end else if (m_last == 0) begin
        if (bit_tvalid) begin
          si.push_back(mapb(m_bpsk != 0 ? bit_tdata[0] : bit_tdata[1]));
          sq.push_back(m_bpsk != 0 ? 0 : mapb(bit_tdata[0]));
          m_last = int'(bit_tlast);
        end else begin
          si.push_back(0);
          sq.push_back(0);
          e_u = 1;
        end
      end else if (m_tail < 0) begin
        si.push_back(0);
        sq.push_back(0);
        m_tail = k + 1;
      end else begin
        m_busy = 0;
      end
      m_t = (m_busy != 0) ? m_t + 1 : 0;
    end else begin
      m_t++;
    end
    e_r = (m_busy != 0 && m_t % SPS == SPS - 1 && m_t / SPS + 1 >= P && m_last == 0) ? 1 : 0;
    chk("I_tdata", int'($signed(I_tdata)), e_i);
    chk("Q_tdata", int'($signed(Q_tdata)), e_q);
    chk("I_tvalid", int'(I_tvalid), e_v);
    chk("Q_tvalid", int'(Q_tvalid), e_v);
    chk("sym_strobe", int'(sym_strobe), e_s);
    chk("underrun", int'(underrun), e_u);
    chk("busy", int'(busy), m_busy);
    chk("bit_tready", int'(bit_tready), e_r);
    if (last_rdy != 0 && bit_tvalid) hs_cnt++;
    last_rdy = int'(bit_tready);
    rdy_cnt += int'(bit_tready);
    busy_cnt += int'(busy);
    strobe_cnt += int'(sym_strobe);
    under_cnt += int'(underrun);
    valid_cnt += int'(I_tvalid);
    if (I_tvalid) begin
      if (last_v == 0) vcnt = 0;
      if (vcnt < 4096) begin
        log_i[vcnt] = int'($signed(I_tdata));
        log_q[vcnt] = int'($signed(Q_tdata));
      end
      vcnt++;
    end
    last_v = int'(I_tvalid);
  end

  task automatic send_frame(input logic bpsk, input int n, input int skip, input logic fixed,
                            input logic chaos, input int rst_slot);
    int sent = 0, slot = 0, guard = 0;
    @(negedge clk);
    start = 1;
    is_bpsk = bpsk;
    @(negedge clk);
    start = 0;
    while (busy) begin
      if (guard++ > 4000) begin
        tests++;
        fails++;
        $display("FAIL frame_timeout: busy still %0d after %0d cycles", busy, guard);
        break;
      end
      if (bit_tready) begin
        if (slot == skip) bit_tvalid = 0;
        else begin
          bit_tvalid = 1;
          bit_tdata = fixed ? fdat[sent % 3] : 2'($urandom);
          bit_tlast = (sent == n - 1);
          sent++;
        end
        if (slot == rst_slot) begin
          repeat (11) @(negedge clk);
          rst = 1;
          start = 1;
          @(negedge clk);
          rst = 0;
          start = 0;
          chk("rst_busy", int'(busy), 0);
          chk("rst_valid", int'(I_tvalid), 0);
          chk("rst_I", int'(I_tdata), 0);
        end
        slot++;
      end else begin
        bit_tvalid = 1'($urandom);
        bit_tdata = 2'($urandom);
        bit_tlast = 1'($urandom);
      end
      if (chaos) begin
        is_bpsk = 1'($urandom);
        start = ($urandom_range(0, 30) == 0);
      end
      @(negedge clk);
    end
    start = 0;
    bit_tvalid = 0;
    bit_tlast = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int r0, b0, s0, h0, u0, v0;
    repeat (5) @(negedge clk);
    rst = 0;
    r0 = rdy_cnt;
    repeat (100) begin
      @(negedge clk);
      bit_tvalid = 1'($urandom);
      bit_tdata = 2'($urandom);
      is_bpsk = 1'($urandom);
    end
    bit_tvalid = 0;
    chk("idle_tready_count", rdy_cnt - r0, 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_I", int'(I_tdata), 0);

    b0 = busy_cnt; s0 = strobe_cnt;
    send_frame(1, 4, 99, 0, 0, 99);
    chk("bpsk_first", log_i[0], 0);
    chk("bpsk_ph31", log_i[31], 7936);
    chk("bpsk_sym2_ph1", log_i[33], 7680);
    chk("bpsk_q", log_q[40], 0);
    chk("bpsk_strobes", strobe_cnt - s0, P + 4 + 1);
    chk("bpsk_busy_len", busy_cnt - b0, (P + 4 + 1) * SPS);

    b0 = busy_cnt; h0 = hs_cnt; v0 = valid_cnt;
    send_frame(0, 3, 99, 1, 0, 99);
    chk("qpsk_handshakes", hs_cnt - h0, 3);
    chk("qpsk_s0_i", log_i[96], 8192);
    chk("qpsk_s0_q", log_q[96], 8192);
    chk("qpsk_s1_i", log_i[128], -8192);
    chk("qpsk_s1_q", log_q[128], 8192);
    chk("qpsk_s2_i", log_i[160], -8192);
    chk("qpsk_s2_q", log_q[160], -8192);
    chk("qpsk_tail_i", log_i[191], -256);
    chk("qpsk_tail_q", log_q[191], -256);
    chk("qpsk_busy_len", busy_cnt - b0, 6 * SPS);
    chk("qpsk_valid_len", valid_cnt - v0, 6 * SPS);

    b0 = busy_cnt; u0 = under_cnt;
    send_frame(0, 4, 1, 0, 0, 99);
    chk("underrun_pulses", under_cnt - u0, 1);
    chk("underrun_sym_i", log_i[128], 0);
    chk("underrun_sym_q", log_q[128], 0);
    chk("underrun_busy_len", busy_cnt - b0, (P + 5 + 1) * SPS);

    b0 = busy_cnt;
    send_frame(1, 3, 99, 0, 1, 99);
    chk("chaos_busy_len", busy_cnt - b0, (P + 3 + 1) * SPS);

    send_frame(0, 3, 99, 0, 0, 1);
    b0 = busy_cnt;
    send_frame(0, 2, 99, 0, 0, 99);
    chk("post_rst_busy_len", busy_cnt - b0, (P + 2 + 1) * SPS);

    repeat (6) send_frame(1'($urandom), $urandom_range(1, 5), $urandom_range(0, 6), 0, 1, 99);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
